// File: rtl/fir_out_collector.sv
// FIR result collector: Q(2*FRAC) -> sample-format requantiser with saturating FWFT FIFO.
// Define FIR_COLLECT_ROUND_EN for round-half-up; default build truncates (floor).
module fir_out_collector #(
   parameter int DATAWIDTH = 16,
   parameter int FRAC      = 8,
   parameter int DEPTH     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2*DATAWIDTH-1:0]     y,
   input  logic                       done,
   input  logic                       clear,
   output logic [DATAWIDTH-1:0]       out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       sat
);

   localparam int YW = 2 * DATAWIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic signed [YW:0] MAXV =
      {{(YW - DATAWIDTH + 2){1'b0}}, {(DATAWIDTH - 1){1'b1}}};
   localparam logic signed [YW:0] MINV =
      {{(YW - DATAWIDTH + 2){1'b1}}, {(DATAWIDTH - 1){1'b0}}};
`ifdef FIR_COLLECT_ROUND_EN
   localparam logic signed [YW:0] RND =
      {{(YW + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
`endif

   logic [YW-1:0]        s_data_q, s_data_d;
   logic                 s_vld_q, s_vld_d;
   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [DATAWIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 sat_q, sat_d;

   logic signed [YW:0]   ext, sum, shr;
   logic                 clamp_hi, clamp_lo;
   logic [DATAWIDTH-1:0] conv;
   logic                 pop, full, push, drop;

   // Guard bit keeps the rounding add from wrapping near full scale.
   always_comb begin
      ext = {s_data_q[YW-1], s_data_q};
`ifdef FIR_COLLECT_ROUND_EN
      sum = ext + RND;
`else
      sum = ext;
`endif
      shr      = sum >>> FRAC;
      clamp_hi = shr > MAXV;
      clamp_lo = shr < MINV;
      if (clamp_hi)
         conv = {1'b0, {(DATAWIDTH - 1){1'b1}}};
      else if (clamp_lo)
         conv = {1'b1, {(DATAWIDTH - 1){1'b0}}};
      else
         conv = shr[DATAWIDTH-1:0];
   end

   always_comb begin
      pop  = (count_q != '0) && out_ready;
      full = count_q == CW'(DEPTH);
      push = s_vld_q && (!full || pop);
      drop = s_vld_q && full && !pop;

      s_vld_d    = done;
      s_data_d   = done ? y : s_data_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      sat_d      = sat_q | (s_vld_q & (clamp_hi | clamp_lo));

      if (push) begin
         mem_d[wr_ptr_q] = conv;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);

      if (clear) begin
         s_vld_d    = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         sat_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_data_q   <= '0;
         s_vld_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         s_data_q   <= s_data_d;
         s_vld_q    <= s_vld_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         sat_q      <= sat_d;
      end
   end

   assign out_data  = mem_q[rd_ptr_q];
   assign out_valid = count_q != '0;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_fir_out_collector.sv
// Scoreboard bench for fir_out_collector: directed vectors, queue-based output checking.
// Expected values follow FIR_COLLECT_ROUND_EN when it is defined.
module tb_fir_out_collector;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] y = '0;
   logic        done = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  count;
   logic        overflow;
   logic        sat;

   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   fir_out_collector #(.DATAWIDTH(16), .FRAC(8), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .y(y), .done(done), .clear(clear),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .overflow(overflow), .sat(sat)
   );

   always #5 clk = ~clk;

`ifdef FIR_COLLECT_ROUND_EN
   localparam logic [15:0] E_P80 = 16'h0001;
   localparam logic [15:0] E_N80 = 16'h0000;
`else
   localparam logic [15:0] E_P80 = 16'h0000;
   localparam logic [15:0] E_N80 = 16'hFFFF;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] v, input bit keep,
                       input logic [15:0] e);
      done = 1'b1;
      y    = v;
      if (keep)
         exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max);
      int k = 0;
      while (count != 4'd0 && k < max) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain", 32'(count), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h, expected none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(mon_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(1);

      // basic path and latency
      out_ready = 1'b1;
      send(32'h0000_4000, 1'b1, 16'h0040);
      done = 1'b0;
      chk("lat_n_valid", 32'(out_valid), 32'd0);
      idle(1);
      chk("lat_n1_valid", 32'(out_valid), 32'd1);
      chk("lat_n1_data", 32'(out_data), 32'h40);
      chk("lat_n1_count", 32'(count), 32'd1);
      idle(1);
      chk("lat_n2_valid", 32'(out_valid), 32'd0);
      chk("lat_n2_count", 32'(count), 32'd0);

      // rounding
      send(32'h0000_0080, 1'b1, E_P80);
      send(32'hFFFF_FF80, 1'b1, E_N80);
      done = 1'b0;
      idle(3);
      chk("round_sat", 32'(sat), 32'd0);
      chk("round_count", 32'(count), 32'd0);

      // saturation
      send(32'h0080_0000, 1'b1, 16'h7FFF);
      send(32'hFF7F_FF00, 1'b1, 16'h8000);
      done = 1'b0;
      idle(3);
      chk("sat_set", 32'(sat), 32'd1);
      send(32'h0000_4000, 1'b1, 16'h0040);
      done = 1'b0;
      idle(3);
      chk("sat_sticky", 32'(sat), 32'd1);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      chk("sat_clear", 32'(sat), 32'd0);
      chk("ovf_clear", 32'(overflow), 32'd0);

      // fill and overflow
      out_ready = 1'b0;
      for (int k = 1; k <= 10; k++)
         send(32'(k) << 16, k <= 8, 16'(k * 256));
      done = 1'b0;
      idle(2);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_head", 32'(out_data), 32'h100);
      out_ready = 1'b1;
      wait_drain(20);
      chk("fill_drained_valid", 32'(out_valid), 32'd0);
      chk("fill_queue", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b0;

      // simultaneous push and pop at full
      for (int k = 1; k <= 8; k++)
         send(32'(k) << 16, 1'b1, 16'(k * 256));
      done = 1'b0;
      idle(2);
      chk("pp_full", 32'(count), 32'd8);
      send(32'h0009_0000, 1'b1, 16'h0900);
      out_ready = 1'b1;
      chk("pp_count0", 32'(count), 32'd8);
      send(32'h000A_0000, 1'b1, 16'h0A00);
      chk("pp_count1", 32'(count), 32'd8);
      send(32'h000B_0000, 1'b1, 16'h0B00);
      chk("pp_count2", 32'(count), 32'd8);
      send(32'h000C_0000, 1'b1, 16'h0C00);
      done = 1'b0;
      chk("pp_count3", 32'(count), 32'd8);
      idle(1);
      out_ready = 1'b0;
      chk("pp_count4", 32'(count), 32'd8);
      chk("pp_overflow", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      wait_drain(20);
      chk("pp_queue", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b0;

      // clear together with done
      send(32'h0080_0000, 1'b0, 16'h0);
      send(32'h0001_0000, 1'b0, 16'h0);
      y     = 32'h0002_0000;
      clear = 1'b1;
      idle(1);
      done  = 1'b0;
      clear = 1'b0;
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_sat", 32'(sat), 32'd0);
      idle(3);
      chk("clr_late_count", 32'(count), 32'd0);
      chk("clr_late_valid", 32'(out_valid), 32'd0);

      // asynchronous reset mid-burst
      send(32'h0080_0000, 1'b0, 16'h0);
      for (int k = 2; k <= 10; k++)
         send(32'(k) << 16, 1'b0, 16'h0);
      chk("ar_pre_count", 32'(count), 32'd8);
      chk("ar_pre_overflow", 32'(overflow), 32'd1);
      chk("ar_pre_sat", 32'(sat), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_data", 32'(out_data), 32'd0);
      chk("ar_overflow", 32'(overflow), 32'd0);
      chk("ar_sat", 32'(sat), 32'd0);
      @(negedge clk);
      done = 1'b0;
      rst  = 1'b1;
      idle(3);
      chk("ar_post_count", 32'(count), 32'd0);
      chk("ar_post_valid", 32'(out_valid), 32'd0);

      chk("final_queue", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
